reg_writeback: RTL and testbench

//  Writeback stage directly upstream of the AAP register file write ports.

---
 rtl/reg_writeback_pkg.sv | 49 ++++
 rtl/reg_writeback_fifo.sv | 51 +++++
 rtl/reg_writeback.sv | 193 +++++++++++++++++++
 tb/tb_reg_writeback.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared constants, types and helpers for the writeback stage.
package reg_writeback_pkg;

  localparam int NREGS        = 16;
  localparam int IDX_W        = 4;   // regnum bits that select a register
  localparam int REGNUM_W     = 6;
  localparam int WORD_W       = 16;
  localparam int LD_DEPTH_DEF = 2;

  // Processor state encoding for "halted".
  localparam logic [2:0] STATE_HALTED = 3'd2;

  // One returned load as it sits in the load-return FIFO.
  typedef struct packed {
    logic [REGNUM_W-1:0] regnum;
    logic [WORD_W-1:0]   data;
  } ld_entry_t;

  localparam int LD_ENTRY_W = $bits(ld_entry_t);

  // Register-file write port chosen for the load path this cycle.
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_A    = 2'd1,
    PORT_B    = 2'd2,
    PORT_D    = 2'd3
  } port_sel_t;

  // Free-port search: d first, then b, then a.
  function automatic port_sel_t pick_free_port(input logic a_busy,
                                               input logic b_busy,
                                               input logic d_busy);
    port_sel_t sel;
    sel = PORT_NONE;
    if (!a_busy) sel = PORT_A;
    if (!b_busy) sel = PORT_B;
    if (!d_busy) sel = PORT_D;
    return sel;
  endfunction

  // One-hot scoreboard mask for a register index.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// Load-return FIFO: DEPTH entries of {regnum, data}, synchronous reset.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module wb_load_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [LD_ENTRY_W-1:0] wr_entry,
  output logic [LD_ENTRY_W-1:0] rd_entry,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [LD_ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign rd_entry = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; reset discards any stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are only meaningful between pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage in front of the register file write ports.
// Execute bundles (slots a/b/d) go straight to ports a/b/d one cycle later.
// Returned loads take whichever port execute leaves free (d, then b, then a),
// at most one per cycle, via a small FIFO or a same-cycle bypass.
// A per-register pending-load scoreboard stalls execute on WAW hazards.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// ready never depends on valid; the sender holds its payload stable while
// valid is high and ready is low. ex_ready and ld_ready are combinational.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int LD_DEPTH = LD_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          state,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_a_we,
  input  logic [REGNUM_W-1:0] ex_a_regnum,
  input  logic [WORD_W-1:0]   ex_a_data,
  input  logic                ex_b_we,
  input  logic [REGNUM_W-1:0] ex_b_regnum,
  input  logic [WORD_W-1:0]   ex_b_data,
  input  logic                ex_d_we,
  input  logic [REGNUM_W-1:0] ex_d_regnum,
  input  logic [WORD_W-1:0]   ex_d_data,
  input  logic                ld_issue,
  input  logic [REGNUM_W-1:0] ld_issue_regnum,
  output logic                ld_issue_ready,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [REGNUM_W-1:0] ld_regnum,
  input  logic [WORD_W-1:0]   ld_data,
  output logic [NREGS-1:0]    pend,
  output logic [REGNUM_W-1:0] rega_wregnum,
  output logic [WORD_W-1:0]   rega_wdata,
  output logic                rega_we,
  output logic [REGNUM_W-1:0] regb_wregnum,
  output logic [WORD_W-1:0]   regb_wdata,
  output logic                regb_we,
  output logic [REGNUM_W-1:0] regd_wregnum,
  output logic [WORD_W-1:0]   regd_wdata,
  output logic                regd_we
);

  logic                  halted;
  logic                  hazard;
  logic                  ex_acc;
  logic                  a_busy;
  logic                  b_busy;
  logic                  d_busy;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LD_ENTRY_W-1:0] fifo_head_bits;
  ld_entry_t             fifo_head;
  ld_entry_t             ld_in;
  ld_entry_t             ld_src;
  logic                  ld_src_valid;
  logic                  ld_go;
  port_sel_t             ld_port;
  logic [IDX_W-1:0]      src_idx;
  logic                  ex_hits_load;
  logic [NREGS-1:0]      pend_set;
  logic [NREGS-1:0]      pend_clr;
  logic                  unused_regnum_hi;

  // Only the low index bits address the scoreboard.
  assign unused_regnum_hi = ^ld_issue_regnum[REGNUM_W-1:IDX_W];

  assign halted         = (state == STATE_HALTED);
  assign ld_issue_ready = ~pend[ld_issue_regnum[IDX_W-1:0]];
  assign ld_ready       = ~fifo_full;
  assign ld_in          = {ld_regnum, ld_data};
  assign fifo_head      = fifo_head_bits;

  // Execute acceptance: stall when halted or when any written slot targets
  // a register with a load still outstanding.
  always_comb begin
    hazard = (ex_a_we & pend[ex_a_regnum[IDX_W-1:0]]) |
             (ex_b_we & pend[ex_b_regnum[IDX_W-1:0]]) |
             (ex_d_we & pend[ex_d_regnum[IDX_W-1:0]]);
    ex_ready = ~halted & ~hazard;
    ex_acc   = ex_valid & ex_ready;
    a_busy   = ex_acc & ex_a_we;
    b_busy   = ex_acc & ex_b_we;
    d_busy   = ex_acc & ex_d_we;
  end

  // Load port allocation: FIFO head first, else bypass the incoming load.
  always_comb begin
    ld_src       = fifo_empty ? ld_in : fifo_head;
    ld_src_valid = ~halted & (fifo_empty ? (ld_valid & ld_ready) : 1'b1);
    ld_port      = pick_free_port(a_busy, b_busy, d_busy);
    ld_go        = ld_src_valid & (ld_port != PORT_NONE);
    fifo_pop     = ld_go & ~fifo_empty;
    fifo_push    = ld_valid & ld_ready & ~(ld_go & fifo_empty);
    src_idx      = ld_src.regnum[IDX_W-1:0];
    ex_hits_load = ld_go & ((a_busy & (ex_a_regnum[IDX_W-1:0] == src_idx)) |
                            (b_busy & (ex_b_regnum[IDX_W-1:0] == src_idx)) |
                            (d_busy & (ex_d_regnum[IDX_W-1:0] == src_idx)));
  end

  // Scoreboard masks: issue sets, load write-out clears.
  always_comb begin
    pend_set = ld_issue ? reg_onehot(ld_issue_regnum[IDX_W-1:0]) : '0;
    pend_clr = ld_go ? reg_onehot(src_idx) : '0;
  end

  wb_load_fifo #(
    .DEPTH (LD_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wr_entry (ld_in),
    .rd_entry (fifo_head_bits),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Scoreboard register; a set and a clear of the same register keeps it set.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_set;
  end

  // Port a output register: execute slot a, else a load routed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rega_we      <= 1'b0;
      rega_wregnum <= '0;
      rega_wdata   <= '0;
    end else begin
      rega_we <= a_busy | (ld_go & (ld_port == PORT_A));
      if (a_busy) begin
        rega_wregnum <= ex_a_regnum;
        rega_wdata   <= ex_a_data;
      end else if (ld_go && ld_port == PORT_A) begin
        rega_wregnum <= ld_src.regnum;
        rega_wdata   <= ld_src.data;
      end
    end
  end

  // Port b output register: execute slot b, else a load routed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      regb_we      <= 1'b0;
      regb_wregnum <= '0;
      regb_wdata   <= '0;
    end else begin
      regb_we <= b_busy | (ld_go & (ld_port == PORT_B));
      if (b_busy) begin
        regb_wregnum <= ex_b_regnum;
        regb_wdata   <= ex_b_data;
      end else if (ld_go && ld_port == PORT_B) begin
        regb_wregnum <= ld_src.regnum;
        regb_wdata   <= ld_src.data;
      end
    end
  end

  // Port d output register: execute slot d, else a load routed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      regd_we      <= 1'b0;
      regd_wregnum <= '0;
      regd_wdata   <= '0;
    end else begin
      regd_we <= d_busy | (ld_go & (ld_port == PORT_D));
      if (d_busy) begin
        regd_wregnum <= ex_d_regnum;
        regd_wdata   <= ex_d_data;
      end else if (ld_go && ld_port == PORT_D) begin
        regd_wregnum <= ld_src.regnum;
        regd_wdata   <= ld_src.data;
      end
    end
  end

  // A load to Rn must never share a write cycle with an execute write to Rn.
  a_no_waw: assert property (@(posedge clk) disable iff (rst) !ex_hits_load);

  // A second load to a register with one outstanding is not allowed.
  a_issue_legal: assert property (@(posedge clk) disable iff (rst)
                                  !(ld_issue && !ld_issue_ready));

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a table of single-cycle execute vectors
// followed by hand-written sequences for loads, stalls, halt and reset.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam logic [2:0] RUN = 3'd0;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic        ex_valid, ex_ready;
  logic        ex_a_we, ex_b_we, ex_d_we;
  logic [5:0]  ex_a_regnum, ex_b_regnum, ex_d_regnum;
  logic [15:0] ex_a_data, ex_b_data, ex_d_data;
  logic        ld_issue, ld_issue_ready;
  logic [5:0]  ld_issue_regnum;
  logic        ld_valid, ld_ready;
  logic [5:0]  ld_regnum;
  logic [15:0] ld_data;
  logic [15:0] pend;
  logic [5:0]  rega_wregnum, regb_wregnum, regd_wregnum;
  logic [15:0] rega_wdata, regb_wdata, regd_wdata;
  logic        rega_we, regb_we, regd_we;

  int total;
  int bad;

  reg_writeback dut (
    .clk (clk), .rst (rst), .state (state),
    .ex_valid (ex_valid), .ex_ready (ex_ready),
    .ex_a_we (ex_a_we), .ex_a_regnum (ex_a_regnum), .ex_a_data (ex_a_data),
    .ex_b_we (ex_b_we), .ex_b_regnum (ex_b_regnum), .ex_b_data (ex_b_data),
    .ex_d_we (ex_d_we), .ex_d_regnum (ex_d_regnum), .ex_d_data (ex_d_data),
    .ld_issue (ld_issue), .ld_issue_regnum (ld_issue_regnum),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid (ld_valid), .ld_ready (ld_ready),
    .ld_regnum (ld_regnum), .ld_data (ld_data),
    .pend (pend),
    .rega_wregnum (rega_wregnum), .rega_wdata (rega_wdata), .rega_we (rega_we),
    .regb_wregnum (regb_wregnum), .regb_wdata (regb_wdata), .regb_we (regb_we),
    .regd_wregnum (regd_wregnum), .regd_wdata (regd_wdata), .regd_we (regd_we)
  );

  // Clock and cycle helper
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Comparison helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic clr_in();
    ex_valid = 0; ex_a_we = 0; ex_b_we = 0; ex_d_we = 0;
    ex_a_regnum = 0; ex_b_regnum = 0; ex_d_regnum = 0;
    ex_a_data = 0; ex_b_data = 0; ex_d_data = 0;
    ld_issue = 0; ld_issue_regnum = 0;
    ld_valid = 0; ld_regnum = 0; ld_data = 0;
  endtask

  task automatic drive_ex(input logic [2:0] we,
                          input logic [5:0] ra, input logic [15:0] da,
                          input logic [5:0] rb, input logic [15:0] db,
                          input logic [5:0] rd, input logic [15:0] dd);
    ex_valid = 1;
    {ex_a_we, ex_b_we, ex_d_we} = we;
    ex_a_regnum = ra; ex_a_data = da;
    ex_b_regnum = rb; ex_b_data = db;
    ex_d_regnum = rd; ex_d_data = dd;
  endtask

  task automatic drive_ld(input logic [5:0] rn, input logic [15:0] d);
    ld_valid = 1; ld_regnum = rn; ld_data = d;
  endtask

  function automatic logic [2:0] we_vec();
    return {rega_we, regb_we, regd_we};
  endfunction

  // Vector table
  typedef struct {
    logic        valid;
    logic [2:0]  we;
    logic [5:0]  rn_a, rn_b, rn_d;
    logic [15:0] d_a, d_b, d_d;
    logic        exp_ready;
    logic [2:0]  exp_we;
  } vec_t;

  vec_t vecs [6];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{1'b1, 3'b111, 6'd1, 6'd2, 6'd3, 16'h1111, 16'h2222, 16'h3333, 1'b1, 3'b111};
    vecs[1] = '{1'b0, 3'b111, 6'd4, 6'd5, 6'd6, 16'h4444, 16'h5555, 16'h6666, 1'b1, 3'b000};
    vecs[2] = '{1'b1, 3'b010, 6'd0, 6'd7, 6'd0, 16'h0000, 16'h0707, 16'h0000, 1'b1, 3'b010};
    vecs[3] = '{1'b1, 3'b101, 6'd9, 6'd0, 6'd9, 16'h00AA, 16'h0000, 16'h00DD, 1'b1, 3'b101};
    vecs[4] = '{1'b1, 3'b111, 6'h3F, 6'h20, 6'h10, 16'hFFFF, 16'h0000, 16'h8001, 1'b1, 3'b111};
    vecs[5] = '{1'b1, 3'b000, 6'd1, 6'd2, 6'd3, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 3'b000};

    // Reset state
    clr_in();
    state = RUN;
    rst   = 1;
    step(); step();
    chk("rst_we", {29'd0, we_vec()}, 32'd0);
    chk("rst_wregnum", {14'd0, rega_wregnum, regb_wregnum, regd_wregnum}, 32'd0);
    chk("rst_wdata_a", {16'd0, rega_wdata}, 32'd0);
    chk("rst_wdata_bd", {regb_wdata, regd_wdata}, 32'd0);
    chk("rst_pend", {16'd0, pend}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    rst = 0;
    #1;
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

    // Table of plain execute bundles
    foreach (vecs[i]) begin
      clr_in();
      drive_ex(vecs[i].we, vecs[i].rn_a, vecs[i].d_a, vecs[i].rn_b, vecs[i].d_b,
               vecs[i].rn_d, vecs[i].d_d);
      ex_valid = vecs[i].valid;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, ex_ready}, {31'd0, vecs[i].exp_ready});
      step();
      chk($sformatf("v%0d_we", i), {29'd0, we_vec()}, {29'd0, vecs[i].exp_we});
      if (vecs[i].exp_we[2])
        chk($sformatf("v%0d_a", i), {10'd0, rega_wregnum, rega_wdata}, {10'd0, vecs[i].rn_a, vecs[i].d_a});
      if (vecs[i].exp_we[1])
        chk($sformatf("v%0d_b", i), {10'd0, regb_wregnum, regb_wdata}, {10'd0, vecs[i].rn_b, vecs[i].d_b});
      if (vecs[i].exp_we[0])
        chk($sformatf("v%0d_d", i), {10'd0, regd_wregnum, regd_wdata}, {10'd0, vecs[i].rn_d, vecs[i].d_d});
    end

    // Issued load to R5 returns with an empty FIFO: bypass onto port d
    clr_in();
    ld_issue = 1; ld_issue_regnum = 6'd5;
    #1;
    chk("ld5_issue_ready", {31'd0, ld_issue_ready}, 32'd1);
    step();
    chk("ld5_pend_set", {16'd0, pend}, 32'h0020);
    clr_in();
    ld_issue_regnum = 6'd5;
    #1;
    chk("ld5_issue_busy", {31'd0, ld_issue_ready}, 32'd0);
    drive_ld(6'd5, 16'hBEEF);
    step();
    chk("ld5_we", {29'd0, we_vec()}, 32'b001);
    chk("ld5_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd5, 16'hBEEF});
    chk("ld5_pend_clr", {16'd0, pend}, 32'd0);

    // Load takes the port execute leaves free: b, then a
    clr_in();
    drive_ex(3'b001, 6'd0, 16'h0, 6'd0, 16'h0, 6'd6, 16'h0606);
    drive_ld(6'd7, 16'h7777);
    step();
    chk("alloc_b_we", {29'd0, we_vec()}, 32'b011);
    chk("alloc_b_b", {10'd0, regb_wregnum, regb_wdata}, {10'd0, 6'd7, 16'h7777});
    chk("alloc_b_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd6, 16'h0606});
    clr_in();
    drive_ex(3'b011, 6'd0, 16'h0, 6'd1, 16'h0101, 6'd2, 16'h0202);
    drive_ld(6'd3, 16'h3003);
    step();
    chk("alloc_a_we", {29'd0, we_vec()}, 32'b111);
    chk("alloc_a_a", {10'd0, rega_wregnum, rega_wdata}, {10'd0, 6'd3, 16'h3003});

    // Issue and write-out of the same register in one cycle: issue wins
    clr_in();
    ld_issue = 1; ld_issue_regnum = 6'd5;
    drive_ld(6'd5, 16'h5555);
    step();
    chk("setwin_pend", {16'd0, pend}, 32'h0020);
    chk("setwin_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd5, 16'h5555});
    clr_in();
    drive_ld(6'd5, 16'h5556);
    step();
    chk("setwin_clr", {16'd0, pend}, 32'd0);

    // Full bundles while three loads arrive: FIFO fills, then drains on d
    clr_in();
    drive_ex(3'b111, 6'd1, 16'h0101, 6'd2, 16'h0202, 6'd3, 16'h0303);
    drive_ld(6'd8, 16'hA001);
    #1;
    chk("fill0_ld_ready", {31'd0, ld_ready}, 32'd1);
    step();
    chk("fill0_we", {29'd0, we_vec()}, 32'b111);
    drive_ex(3'b111, 6'd1, 16'h1010, 6'd2, 16'h2020, 6'd3, 16'h3030);
    drive_ld(6'd9, 16'hA002);
    #1;
    chk("fill1_ld_ready", {31'd0, ld_ready}, 32'd1);
    step();
    chk("fill1_we", {29'd0, we_vec()}, 32'b111);
    clr_in();
    drive_ld(6'd10, 16'hA003);
    #1;
    chk("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    step();
    chk("drain0_we", {29'd0, we_vec()}, 32'b001);
    chk("drain0_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd8, 16'hA001});
    #1;
    chk("drain0_ld_ready", {31'd0, ld_ready}, 32'd1);
    step();
    chk("drain1_we", {29'd0, we_vec()}, 32'b001);
    chk("drain1_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd9, 16'hA002});
    clr_in();
    step();
    chk("drain2_we", {29'd0, we_vec()}, 32'b001);
    chk("drain2_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd10, 16'hA003});
    step();
    chk("drain3_we", {29'd0, we_vec()}, 32'b000);

    // Pending load on R4 stalls an execute write to R4
    clr_in();
    ld_issue = 1; ld_issue_regnum = 6'd4;
    step();
    chk("waw_pend", {16'd0, pend}, 32'h0010);
    clr_in();
    drive_ex(3'b001, 6'd0, 16'h0, 6'd0, 16'h0, 6'd4, 16'h4444);
    #1;
    chk("waw_stall0", {31'd0, ex_ready}, 32'd0);
    step();
    chk("waw_stall0_we", {29'd0, we_vec()}, 32'b000);
    drive_ld(6'd4, 16'h0404);
    #1;
    chk("waw_stall1", {31'd0, ex_ready}, 32'd0);
    step();
    chk("waw_ld_we", {29'd0, we_vec()}, 32'b001);
    chk("waw_ld_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd4, 16'h0404});
    chk("waw_pend_clr", {16'd0, pend}, 32'd0);
    ld_valid = 0;
    #1;
    chk("waw_ready", {31'd0, ex_ready}, 32'd1);
    step();
    chk("waw_ex_we", {29'd0, we_vec()}, 32'b001);
    chk("waw_ex_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd4, 16'h4444});

    // Halt with one load queued: nothing written until halt drops
    clr_in();
    state = STATE_HALTED;
    drive_ex(3'b100, 6'd1, 16'h0F0F, 6'd0, 16'h0, 6'd0, 16'h0);
    drive_ld(6'd11, 16'hB0B0);
    #1;
    chk("halt_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("halt_ld_ready", {31'd0, ld_ready}, 32'd1);
    step();
    chk("halt0_we", {29'd0, we_vec()}, 32'b000);
    ld_valid = 0;
    for (int c = 1; c < 3; c++) begin
      step();
      chk($sformatf("halt%0d_we", c), {29'd0, we_vec()}, 32'b000);
    end
    clr_in();
    state = RUN;
    step();
    chk("unhalt_we", {29'd0, we_vec()}, 32'b001);
    chk("unhalt_d", {10'd0, regd_wregnum, regd_wdata}, {10'd0, 6'd11, 16'hB0B0});

    // Reset with the FIFO full and a load outstanding
    clr_in();
    ld_issue = 1; ld_issue_regnum = 6'd12;
    step();
    clr_in();
    state = STATE_HALTED;
    drive_ld(6'd13, 16'hD013);
    step();
    drive_ld(6'd14, 16'hD014);
    step();
    clr_in();
    #1;
    chk("prerst_full", {31'd0, ld_ready}, 32'd0);
    chk("prerst_pend", {16'd0, pend}, 32'h1000);
    state = RUN;
    rst   = 1;
    step();
    chk("midrst_pend", {16'd0, pend}, 32'd0);
    chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("midrst_we", {29'd0, we_vec()}, 32'b000);
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("postrst%0d_we", c), {29'd0, we_vec()}, 32'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
